// File: rtl/scan_sequencer.sv
// Scan select generator for a 2-to-4 decoder: per-slot blanking, masked lines, frame-done pulse.
// Optional macro SCAN_HOLD_EN adds a hold input that freezes the scan outside IDLE.
module scan_sequencer #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] mask,
`ifdef SCAN_HOLD_EN
  input  logic       hold,
`endif
  output logic [1:0] sel,
  output logic       en,
  output logic       frame_done,
  output logic       busy
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL1  = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ACTIVE} state_t;

  state_t          state, state_d, start_state;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      sel_d, nsel;
  logic            en_d, fd, fd_d, freeze;

  // Next set mask bit above cur, wrapping; cur itself is checked last.
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] idx;
    next_sel = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) next_sel = idx;
    end
  endfunction

`ifdef SCAN_HOLD_EN
  assign freeze     = hold && (state != S_IDLE);
  assign frame_done = fd && !hold;
`else
  assign freeze     = 1'b0;
  assign frame_done = fd;
`endif

  assign busy        = (state != S_IDLE);
  assign start_state = (BLANK == 0) ? S_ACTIVE : S_BLANK;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    en_d    = en;
    fd_d    = 1'b0;
    nsel    = next_sel(sel, mask);
    case (state)
      S_IDLE: begin
        en_d = 1'b0;
        if (run && (mask != 4'd0)) begin
          state_d = start_state;
          cnt_d   = '0;
          sel_d   = next_sel(2'd3, mask);
          en_d    = (BLANK == 0);
        end
      end
      S_BLANK: begin
        cnt_d = cnt + 1'b1;
        if (cnt == BL1) begin
          state_d = S_ACTIVE;
          en_d    = 1'b1;
        end
      end
      S_ACTIVE: begin
        en_d  = 1'b1;
        cnt_d = cnt + 1'b1;
        if (cnt == LAST) begin
          cnt_d = '0;
          if (!run || (mask == 4'd0)) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
          end else begin
            state_d = start_state;
            sel_d   = nsel;
            fd_d    = (nsel <= sel);
            en_d    = (BLANK == 0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
    // Hold keeps everything, including a pending frame pulse, until released.
    if (freeze) begin
      state_d = state;
      cnt_d   = cnt;
      sel_d   = sel;
      en_d    = en;
      fd_d    = fd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      sel   <= 2'd0;
      en    <= 1'b0;
      fd    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sel   <= sel_d;
      en    <= en_d;
      fd    <= fd_d;
    end
  end

endmodule
